fast_field_decoder: RTL

FAST_FIELD_DECODER -- requirements
Module: fast_field_decoder

---
 rtl/fast_field_decoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/fast_field_decoder.sv
// fast_field_decoder: accumulates stop-bit encoded field chunks into an unsigned integer with flags
module fast_field_decoder #(
    parameter int beat_width      = 64,
    parameter int value_width     = 64,
    parameter int max_field_bytes = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [beat_width-1:0]  in_data,
    input  logic [3:0]             in_nbytes,
    input  logic                   in_complete,
    input  logic                   in_pmap,
    input  logic                   in_tid,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [value_width-1:0] out_value,
    output logic [3:0]             out_nbytes,
    output logic                   out_pmap,
    output logic                   out_tid,
    output logic                   out_overflow,
    output logic                   out_err
);
    localparam int max_b = (beat_width / 8 < 8) ? beat_width / 8 : 8;
    localparam int aw = value_width + 56;
    localparam logic [0:0] st_idle = 1'b0;
    localparam logic [0:0] st_accum = 1'b1;

    logic [0:0]             state;
    logic [value_width-1:0] acc;
    logic [3:0]             cnt;
    logic                   pmap_q, tid_q, ovf_q, err_q, stop_q;
    logic [63:0]            bytes;
    logic [3:0]             n;
    logic [5:0]             shamt;
    logic [55:0]            payload;
    logic [aw-1:0]          wide;
    logic [4:0]             sum;
    logic [3:0]             cnt_next;
    logic                   mid_stop, last_in, has_bytes, held, stop_next;
    logic                   ovf_next, err_next, fire, done;

    assign in_ready = ~out_valid | out_ready;
    assign fire = in_valid & in_ready;
    assign done = fire & in_complete;
    assign bytes = 64'(in_data);

    // Merge the incoming chunk into the running field: shifted accumulator, byte count and sticky flags.
    // The stop bit of a chunk's last byte is only judged once we know whether more bytes follow.
    always_comb begin
        n = (in_nbytes > 4'(max_b)) ? 4'(max_b) : in_nbytes;
        shamt = 6'(n) * 6'd7;
        payload = '0;
        mid_stop = 1'b0;
        last_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(n)) begin
                payload = {payload[48:0], bytes[8*i +: 7]};
                mid_stop = mid_stop | (bytes[8*i+7] & (i < int'(n) - 1));
            end
            if (i == int'(n) - 1) last_in = bytes[8*i+7];
        end
        wide = ({56'b0, acc} << shamt) | aw'(payload);
        sum = 5'(cnt) + 5'(n);
        cnt_next = (sum > 5'd15) ? 4'd15 : sum[3:0];
        has_bytes = n != 4'd0;
        held = (state == st_accum) | has_bytes;
        stop_next = has_bytes ? last_in : stop_q;
        ovf_next = ovf_q | (|wide[aw-1:value_width]) | (int'(sum) > max_field_bytes);
        err_next = err_q | (has_bytes & (mid_stop | ((state == st_accum) & stop_q)));
    end

    // Partial-field state: cleared on reset or when a field completes, otherwise updated per accepted chunk.
    always_ff @(posedge clk) begin
        if (!rstn || done) begin
            state  <= st_idle;
            acc    <= '0;
            cnt    <= '0;
            pmap_q <= 1'b0;
            tid_q  <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            stop_q <= 1'b0;
        end else if (fire) begin
            state  <= held ? st_accum : st_idle;
            acc    <= wide[value_width-1:0];
            cnt    <= cnt_next;
            pmap_q <= pmap_q | in_pmap;
            tid_q  <= tid_q | in_tid;
            ovf_q  <= ovf_next;
            err_q  <= err_next;
            stop_q <= stop_next;
        end
    end

    // Output register: loads a finished field, holds under backpressure, drops valid after handshake.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid    <= 1'b0;
            out_value    <= '0;
            out_nbytes   <= '0;
            out_pmap     <= 1'b0;
            out_tid      <= 1'b0;
            out_overflow <= 1'b0;
            out_err      <= 1'b0;
        end else if (done) begin
            out_valid    <= 1'b1;
            out_value    <= wide[value_width-1:0];
            out_nbytes   <= cnt_next;
            out_pmap     <= pmap_q | in_pmap;
            out_tid      <= tid_q | in_tid;
            out_overflow <= ovf_next;
            out_err      <= err_next | (held & ~stop_next);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
